// File: rtl/instr_fetch_ctrl.sv
// Fetch/dispatch stage: fetches a program word at the PC, holds it in the
// instruction register, launches the execution FSMs and owns the PC and watchdog.
module instr_fetch_ctrl #(
    parameter int PC_W    = 8,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [15:0]     memData,
    input  logic            memValid,
    output logic            memReq,
    output logic [PC_W-1:0] memAddr,
    output logic [15:0]     instruction,
    output logic [3:0]      opClass,
    output logic            execStart,
    input  logic            done,
    input  logic            pcInc,
    input  logic            pcLoad,
    input  logic [PC_W-1:0] pcLoadAddr,
    output logic            halted,
    output logic            fault
);

    typedef enum logic [2:0] {
        RESET,
        FETCH,
        DECODE,
        EXEC,
        HALT,
        FAULT
    } state_t;

    localparam logic [15:0] NOP_WORD    = 16'h0000;
    localparam logic [15:0] HALT_WORD   = 16'hFFFF;
    localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

    state_t            state, state_next;
    logic [PC_W-1:0]   pc, pc_next;
    logic [15:0]       ir, ir_next;
    logic [15:0]       wdog, wdog_next;
    logic              start_q, start_next;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= RESET;
            pc      <= '0;
            ir      <= '0;
            wdog    <= '0;
            start_q <= 1'b0;
        end else begin
            state   <= state_next;
            pc      <= pc_next;
            ir      <= ir_next;
            wdog    <= wdog_next;
            start_q <= start_next;
        end
    end

    // The start pulse is registered on the fetch edge so it lands in DECODE
    // together with the freshly loaded instruction register.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        ir_next    = ir;
        wdog_next  = wdog;
        start_next = 1'b0;
        case (state)
            RESET: state_next = FETCH;
            FETCH: begin
                if (memValid) begin
                    ir_next    = memData;
                    state_next = DECODE;
                    start_next = (memData != NOP_WORD) && (memData != HALT_WORD);
                end
            end
            DECODE: begin
                if (ir == NOP_WORD) begin
                    pc_next    = pc + PC_W'(1);
                    state_next = FETCH;
                end else if (ir == HALT_WORD) begin
                    state_next = HALT;
                end else begin
                    wdog_next  = '0;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                // A timeout cycle discards any PC request arriving with it.
                if (!done && (wdog + 16'd1 == TIMEOUT_CNT)) begin
                    state_next = FAULT;
                end else begin
                    if (pcLoad)
                        pc_next = pcLoadAddr;
                    else if (pcInc)
                        pc_next = pc + PC_W'(1);
                    if (done)
                        state_next = FETCH;
                    else
                        wdog_next = wdog + 16'd1;
                end
            end
            HALT:    state_next = HALT;
            FAULT:   state_next = FAULT;
            default: state_next = RESET;
        endcase
    end

    assign memReq      = (state == FETCH);
    assign memAddr     = pc;
    assign instruction = ir;
    assign opClass     = ir[15:12];
    assign execStart   = start_q;
    assign halted      = (state == HALT) || (state == FAULT);
    assign fault       = (state == FAULT);

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed self-checking bench for instr_fetch_ctrl (watchdog TIMEOUT = 10).
module tb_instr_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] memData;
    logic        memValid;
    logic        memReq;
    logic [7:0]  memAddr;
    logic [15:0] instruction;
    logic [3:0]  opClass;
    logic        execStart;
    logic        done;
    logic        pcInc;
    logic        pcLoad;
    logic [7:0]  pcLoadAddr;
    logic        halted;
    logic        fault;

    int compared   = 0;
    int mismatched = 0;

    instr_fetch_ctrl #(.PC_W(8), .TIMEOUT(10)) dut (
        .clk(clk),
        .rst(rst),
        .memData(memData),
        .memValid(memValid),
        .memReq(memReq),
        .memAddr(memAddr),
        .instruction(instruction),
        .opClass(opClass),
        .execStart(execStart),
        .done(done),
        .pcInc(pcInc),
        .pcLoad(pcLoad),
        .pcLoadAddr(pcLoadAddr),
        .halted(halted),
        .fault(fault)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled and inputs driven 1 time unit after the edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        memData    = 16'h0000;
        memValid   = 1'b0;
        done       = 1'b0;
        pcInc      = 1'b0;
        pcLoad     = 1'b0;
        pcLoadAddr = 8'h00;
    endtask

    // Leaves the DUT in its first FETCH cycle after reset.
    task automatic apply_reset();
        clear_inputs();
        rst = 1'b0;
        cycle();
        cycle();
        rst = 1'b1;
        cycle();
    endtask

    // From FETCH: zero-wait fetch of word, then one EXEC cycle with done; ends in FETCH.
    task automatic run_instr(input logic [15:0] word, input logic inc, input logic load,
                             input logic [7:0] addr);
        memData  = word;
        memValid = 1'b1;
        cycle();
        memValid = 1'b0;
        cycle();
        pcInc      = inc;
        pcLoad     = load;
        pcLoadAddr = addr;
        done       = 1'b1;
        cycle();
        clear_inputs();
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b0;
        cycle();
        cycle();
        compared++; if (memReq !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_memReq: got %b expected 0", memReq); end
        compared++; if (memAddr !== 8'h00) begin mismatched++; $display("[TB] FAIL reset_memAddr: got %h expected 00", memAddr); end
        compared++; if (instruction !== 16'h0000) begin mismatched++; $display("[TB] FAIL reset_instruction: got %h expected 0000", instruction); end
        compared++; if (execStart !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_execStart: got %b expected 0", execStart); end
        compared++; if (halted !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_halted: got %b expected 0", halted); end
        compared++; if (fault !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_fault: got %b expected 0", fault); end
        rst = 1'b1;
        cycle();
        compared++; if (memReq !== 1'b1) begin mismatched++; $display("[TB] FAIL first_fetch_memReq: got %b expected 1", memReq); end
        compared++; if (memAddr !== 8'h00) begin mismatched++; $display("[TB] FAIL first_fetch_memAddr: got %h expected 00", memAddr); end
    endtask

    task automatic test_mov();
        apply_reset();
        memData  = 16'h4042;
        memValid = 1'b1;
        cycle();
        compared++; if (execStart !== 1'b1) begin mismatched++; $display("[TB] FAIL mov_execStart: got %b expected 1", execStart); end
        compared++; if (instruction !== 16'h4042) begin mismatched++; $display("[TB] FAIL mov_instruction: got %h expected 4042", instruction); end
        compared++; if (opClass !== 4'h4) begin mismatched++; $display("[TB] FAIL mov_opClass: got %h expected 4", opClass); end
        compared++; if (memReq !== 1'b0) begin mismatched++; $display("[TB] FAIL mov_decode_memReq: got %b expected 0", memReq); end
        memValid = 1'b0;
        cycle();
        compared++; if (execStart !== 1'b0) begin mismatched++; $display("[TB] FAIL mov_execStart_pulse: got %b expected 0", execStart); end
        pcInc = 1'b1;
        done  = 1'b1;
        cycle();
        clear_inputs();
        compared++; if (memReq !== 1'b1) begin mismatched++; $display("[TB] FAIL mov_refetch_memReq: got %b expected 1", memReq); end
        compared++; if (memAddr !== 8'h01) begin mismatched++; $display("[TB] FAIL mov_next_addr: got %h expected 01", memAddr); end
        compared++; if (instruction !== 16'h4042) begin mismatched++; $display("[TB] FAIL mov_ir_held: got %h expected 4042", instruction); end
    endtask

    task automatic test_wait_states();
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            compared++; if (memReq !== 1'b1) begin mismatched++; $display("[TB] FAIL wait_memReq[%0d]: got %b expected 1", i, memReq); end
            compared++; if (memAddr !== 8'h00) begin mismatched++; $display("[TB] FAIL wait_memAddr[%0d]: got %h expected 00", i, memAddr); end
            compared++; if (instruction !== 16'h0000) begin mismatched++; $display("[TB] FAIL wait_ir[%0d]: got %h expected 0000", i, instruction); end
            memData  = 16'h1234;
            memValid = 1'b0;
            cycle();
        end
        compared++; if (memReq !== 1'b1) begin mismatched++; $display("[TB] FAIL wait_memReq_valid: got %b expected 1", memReq); end
        memData  = 16'h2345;
        memValid = 1'b1;
        cycle();
        memValid = 1'b0;
        compared++; if (instruction !== 16'h2345) begin mismatched++; $display("[TB] FAIL wait_ir_loaded: got %h expected 2345", instruction); end
        compared++; if (execStart !== 1'b1) begin mismatched++; $display("[TB] FAIL wait_execStart: got %b expected 1", execStart); end
        cycle();
        done = 1'b1;
        cycle();
        clear_inputs();
        compared++; if (memAddr !== 8'h00) begin mismatched++; $display("[TB] FAIL wait_no_inc_addr: got %h expected 00", memAddr); end
        compared++; if (memReq !== 1'b1) begin mismatched++; $display("[TB] FAIL wait_refetch: got %b expected 1", memReq); end
    endtask

    task automatic test_nop_halt();
        apply_reset();
        memData  = 16'h0000;
        memValid = 1'b1;
        cycle();
        memValid = 1'b0;
        compared++; if (execStart !== 1'b0) begin mismatched++; $display("[TB] FAIL nop_execStart: got %b expected 0", execStart); end
        cycle();
        compared++; if (memReq !== 1'b1) begin mismatched++; $display("[TB] FAIL nop_refetch: got %b expected 1", memReq); end
        compared++; if (memAddr !== 8'h01) begin mismatched++; $display("[TB] FAIL nop_pc: got %h expected 01", memAddr); end
        memData  = 16'hFFFF;
        memValid = 1'b1;
        cycle();
        memValid = 1'b0;
        compared++; if (execStart !== 1'b0) begin mismatched++; $display("[TB] FAIL halt_execStart: got %b expected 0", execStart); end
        cycle();
        compared++; if (halted !== 1'b1) begin mismatched++; $display("[TB] FAIL halt_halted: got %b expected 1", halted); end
        compared++; if (fault !== 1'b0) begin mismatched++; $display("[TB] FAIL halt_fault: got %b expected 0", fault); end
        for (int i = 0; i < 5; i++) begin
            pcInc      = 1'b1;
            pcLoad     = 1'b1;
            pcLoadAddr = 8'h55;
            done       = 1'b1;
            memValid   = 1'b1;
            memData    = 16'h1111;
            cycle();
            compared++; if (memReq !== 1'b0) begin mismatched++; $display("[TB] FAIL halt_memReq[%0d]: got %b expected 0", i, memReq); end
            compared++; if (memAddr !== 8'h01) begin mismatched++; $display("[TB] FAIL halt_pc_held[%0d]: got %h expected 01", i, memAddr); end
            compared++; if (halted !== 1'b1) begin mismatched++; $display("[TB] FAIL halt_stays[%0d]: got %b expected 1", i, halted); end
        end
        clear_inputs();
    endtask

    task automatic test_branch();
        apply_reset();
        run_instr(16'h1001, 1'b1, 1'b1, 8'h3C);
        compared++; if (memAddr !== 8'h3C) begin mismatched++; $display("[TB] FAIL branch_priority: got %h expected 3c", memAddr); end
        run_instr(16'h2002, 1'b0, 1'b1, 8'hFF);
        compared++; if (memAddr !== 8'hFF) begin mismatched++; $display("[TB] FAIL branch_load_ff: got %h expected ff", memAddr); end
        run_instr(16'h3003, 1'b1, 1'b0, 8'h00);
        compared++; if (memAddr !== 8'h00) begin mismatched++; $display("[TB] FAIL pc_wrap: got %h expected 00", memAddr); end
        compared++; if (memReq !== 1'b1) begin mismatched++; $display("[TB] FAIL pc_wrap_fetch: got %b expected 1", memReq); end
    endtask

    task automatic test_watchdog();
        logic [7:0] exp_pc;
        apply_reset();
        exp_pc   = 8'h00;
        memData  = 16'h5000;
        memValid = 1'b1;
        cycle();
        memValid = 1'b0;
        cycle();
        for (int k = 1; k <= 10; k++) begin
            compared++; if (fault !== 1'b0) begin mismatched++; $display("[TB] FAIL wd_early_fault[%0d]: got %b expected 0", k, fault); end
            compared++; if (memAddr !== exp_pc) begin mismatched++; $display("[TB] FAIL wd_pc[%0d]: got %h expected %h", k, memAddr, exp_pc); end
            pcInc = (k == 1) || (k == 3) || (k == 10);
            cycle();
            if (pcInc && k < 10) exp_pc = exp_pc + 8'h01;
            pcInc = 1'b0;
        end
        compared++; if (fault !== 1'b1) begin mismatched++; $display("[TB] FAIL wd_fault: got %b expected 1", fault); end
        compared++; if (halted !== 1'b1) begin mismatched++; $display("[TB] FAIL wd_halted: got %b expected 1", halted); end
        compared++; if (memAddr !== 8'h02) begin mismatched++; $display("[TB] FAIL wd_final_pc: got %h expected 02", memAddr); end
        done = 1'b1;
        cycle();
        cycle();
        clear_inputs();
        compared++; if (fault !== 1'b1) begin mismatched++; $display("[TB] FAIL wd_fault_sticky: got %b expected 1", fault); end
        compared++; if (memReq !== 1'b0) begin mismatched++; $display("[TB] FAIL wd_memReq: got %b expected 0", memReq); end
    endtask

    task automatic test_reset_mid_exec();
        apply_reset();
        run_instr(16'h1000, 1'b0, 1'b1, 8'h20);
        memData  = 16'h3003;
        memValid = 1'b1;
        cycle();
        memValid = 1'b0;
        cycle();
        pcInc = 1'b1;
        done  = 1'b1;
        rst   = 1'b0;
        cycle();
        compared++; if (memReq !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_memReq: got %b expected 0", memReq); end
        compared++; if (memAddr !== 8'h00) begin mismatched++; $display("[TB] FAIL mid_memAddr: got %h expected 00", memAddr); end
        compared++; if (instruction !== 16'h0000) begin mismatched++; $display("[TB] FAIL mid_instruction: got %h expected 0000", instruction); end
        compared++; if (execStart !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_execStart: got %b expected 0", execStart); end
        compared++; if (halted !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_halted: got %b expected 0", halted); end
        compared++; if (fault !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_fault: got %b expected 0", fault); end
        clear_inputs();
        rst = 1'b1;
        cycle();
        compared++; if (memReq !== 1'b1) begin mismatched++; $display("[TB] FAIL mid_refetch: got %b expected 1", memReq); end
        compared++; if (memAddr !== 8'h00) begin mismatched++; $display("[TB] FAIL mid_refetch_addr: got %h expected 00", memAddr); end
    endtask

    initial begin
        rst = 1'b0;
        clear_inputs();
        test_reset();
        test_mov();
        test_wait_states();
        test_nop_halt();
        test_branch();
        test_watchdog();
        test_reset_mid_exec();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
